// File: rtl/btn_debounce_multi.sv
// btn_debounce_multi
// Multi-channel button conditioner. Each raw pin goes through a two-flop
// synchroniser and a polarity normaliser. A debounce counter then advances on
// the shared prescaler tick. The debounced level drives press/release strobes
// and a per-channel hold FSM, which produces long-press and auto-repeat strobes.
//
// Ports:
//   clk         in            system clock, rising edge
//   rst         in            synchronous active-high reset
//   btn_in      in  [N_CH]    raw asynchronous button pins
//   btn_level   out [N_CH]    debounced state, 1 = pressed
//   btn_press   out [N_CH]    one-cycle strobe on debounced rise
//   btn_release out [N_CH]    one-cycle strobe on debounced fall
//   btn_long    out [N_CH]    one-cycle strobe when hold reaches LONG_TICKS
//   btn_repeat  out [N_CH]    one-cycle strobe every REP_TICKS after long press
module btn_debounce_multi #(
  parameter int N_CH        = 5,
  parameter int TICK_DIV    = 100_000,
  parameter int DEB_TICKS   = 20,
  parameter int LONG_TICKS  = 1000,
  parameter int REP_TICKS   = 200,
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_long,
  output logic [N_CH-1:0] btn_repeat
);

  localparam int DIV_W    = $clog2(TICK_DIV);
  localparam int DEB_W    = $clog2(DEB_TICKS + 1);
  // One hold counter serves both the long-press and the repeat phase.
  localparam int HOLD_MAX = (LONG_TICKS > REP_TICKS) ? LONG_TICKS : REP_TICKS;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_TICKS - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_TICKS - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'((REP_TICKS > 0) ? REP_TICKS - 1 : 0);
  localparam logic [N_CH-1:0]   IDLE_PIN  = ACTIVE_HIGH ? '0 : '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_REPEAT
  } hold_state_e;

  logic [N_CH-1:0]   sync1_q, sync1_d;
  logic [N_CH-1:0]   sync2_q, sync2_d;
  logic [N_CH-1:0]   pressed;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              tick;
  logic [DEB_W-1:0]  deb_q [N_CH];
  logic [DEB_W-1:0]  deb_d [N_CH];
  logic [N_CH-1:0]   level_q, level_d;
  logic [N_CH-1:0]   level_rise, level_fall;
  logic [N_CH-1:0]   press_q, press_d;
  logic [N_CH-1:0]   release_q, release_d;
  logic [N_CH-1:0]   long_q, long_d;
  logic [N_CH-1:0]   repeat_q, repeat_d;
  hold_state_e       state_q [N_CH];
  hold_state_e       state_d [N_CH];
  logic [HOLD_W-1:0] hold_q [N_CH];
  logic [HOLD_W-1:0] hold_d [N_CH];

  // Synchroniser chain and polarity normalisation: downstream logic only
  // ever sees 1 = pressed.
  always_comb begin : sync_comb
    sync1_d = btn_in;
    sync2_d = sync1_q;
    pressed = ACTIVE_HIGH ? sync2_q : ~sync2_q;
  end

  // Shared prescaler: tick marks the last count of each period.
  always_comb begin : prescaler_comb
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + DIV_W'(1);
  end

  // Debounce: progress is kept only while the synchronised input disagrees
  // with the debounced level. Any agreement, even between ticks, wipes it.
  always_comb begin : debounce_comb
    for (int i = 0; i < N_CH; i++) begin
      deb_d[i]   = deb_q[i];
      level_d[i] = level_q[i];
      if (pressed[i] == level_q[i]) begin
        deb_d[i] = '0;
      end else if (tick) begin
        if (deb_q[i] == DEB_LAST) begin
          level_d[i] = ~level_q[i];
          deb_d[i]   = '0;
        end else begin
          deb_d[i] = deb_q[i] + DEB_W'(1);
        end
      end
    end
    level_rise = level_d & ~level_q;
    level_fall = ~level_d & level_q;
    // Registered alongside the level, so a strobe lines up with the first
    // cycle that btn_level shows the new value.
    press_d    = level_rise;
    release_d  = level_fall;
  end

  // Hold FSM next state. A debounced fall overrides everything else, so an
  // event due on the release tick never fires.
  always_comb begin : hold_next_comb
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      hold_d[i]  = hold_q[i];
      if (level_fall[i]) begin
        state_d[i] = ST_IDLE;
        hold_d[i]  = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (level_rise[i]) begin
              state_d[i] = ST_HELD;
              hold_d[i]  = '0;
            end
          end
          ST_HELD: begin
            if (tick) begin
              if (hold_q[i] == LONG_LAST) begin
                state_d[i] = ST_REPEAT;
                hold_d[i]  = '0;
              end else begin
                hold_d[i] = hold_q[i] + HOLD_W'(1);
              end
            end
          end
          ST_REPEAT: begin
            if (tick && (REP_TICKS > 0)) begin
              if (hold_q[i] == REP_LAST) begin
                hold_d[i] = '0;
              end else begin
                hold_d[i] = hold_q[i] + HOLD_W'(1);
              end
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            hold_d[i]  = '0;
          end
        endcase
      end
    end
  end

  // Hold FSM outputs: long/repeat strobes for the terminal tick of each
  // phase, suppressed when the same tick releases the button.
  always_comb begin : hold_out_comb
    long_d   = '0;
    repeat_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (tick && !level_fall[i]) begin
        if ((state_q[i] == ST_HELD) && (hold_q[i] == LONG_LAST)) begin
          long_d[i] = 1'b1;
        end
        if ((REP_TICKS > 0) && (state_q[i] == ST_REPEAT) && (hold_q[i] == REP_LAST)) begin
          repeat_d[i] = 1'b1;
        end
      end
    end
  end

  // All state registers. The synchroniser resets to the idle pin level, so
  // a button held through reset is seen as a fresh press.
  always_ff @(posedge clk) begin : state_regs
    if (rst) begin
      sync1_q   <= IDLE_PIN;
      sync2_q   <= IDLE_PIN;
      div_q     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      repeat_q  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        deb_q[i]   <= '0;
        state_q[i] <= ST_IDLE;
        hold_q[i]  <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      div_q     <= div_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      for (int i = 0; i < N_CH; i++) begin
        deb_q[i]   <= deb_d[i];
        state_q[i] <= state_d[i];
        hold_q[i]  <= hold_d[i];
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_long    = long_q;
  assign btn_repeat  = repeat_q;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// tb_btn_debounce_multi
// Drives two copies of btn_debounce_multi: one active-high and one active-low.
// The active-low copy gets the inverted pins, so both copies must produce
// identical outputs. A reference model works from the pin history, tick
// arithmetic and event deadlines. It pushes the expected outputs for every
// cycle into a queue. A monitor on the falling edge pops each entry and
// compares it against both copies.
module tb_btn_debounce_multi;

  localparam int TD   = 4;
  localparam int DEB  = 3;
  localparam int LONG = 8;
  localparam int REP  = 2;

  typedef struct packed {
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rel;
    logic [1:0] lng;
    logic [1:0] rep;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [1:0] btn_in;
  logic [1:0] btn_in_n;
  logic [1:0] ah_level, ah_press, ah_release, ah_long, ah_repeat;
  logic [1:0] al_level, al_press, al_release, al_long, al_repeat;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  assign btn_in_n = ~btn_in;

  btn_debounce_multi #(
    .N_CH(2), .TICK_DIV(TD), .DEB_TICKS(DEB), .LONG_TICKS(LONG),
    .REP_TICKS(REP), .ACTIVE_HIGH(1'b1)
  ) dut_ah (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_level(ah_level), .btn_press(ah_press), .btn_release(ah_release),
    .btn_long(ah_long), .btn_repeat(ah_repeat)
  );

  btn_debounce_multi #(
    .N_CH(2), .TICK_DIV(TD), .DEB_TICKS(DEB), .LONG_TICKS(LONG),
    .REP_TICKS(REP), .ACTIVE_HIGH(1'b0)
  ) dut_al (
    .clk(clk), .rst(rst), .btn_in(btn_in_n),
    .btn_level(al_level), .btn_press(al_press), .btn_release(al_release),
    .btn_long(al_long), .btn_repeat(al_repeat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] pins, input logic r, input int cycles);
    btn_in = pins;
    rst    = r;
    repeat (cycles) @(negedge clk);
  endtask

  // Reference model. ph counts cycles since reset; a tick happens when
  // ph mod TD == TD-1. The level toggles once an unbroken run of
  // disagreeing cycles contains DEB ticks. Long and repeat events are
  // deadlines measured in ticks from the press.
  int         ph;
  logic [1:0] m_p1, m_p2, m_lvl;
  bit         m_run[2];
  int         m_run_start[2];
  bit         m_held[2];
  bit         m_first[2];
  int         m_next[2];
  bit         m_tick;
  exp_t       m_e;

  initial begin : ref_model
    forever begin
      @(posedge clk);
      m_e = '0;
      if (rst) begin
        ph    = 0;
        m_p1  = '0;
        m_p2  = '0;
        m_lvl = '0;
        for (int c = 0; c < 2; c++) begin
          m_run[c]  = 1'b0;
          m_held[c] = 1'b0;
        end
      end else begin
        m_tick = ((ph % TD) == TD - 1);
        for (int c = 0; c < 2; c++) begin
          bit rose, fell;
          rose = 1'b0;
          fell = 1'b0;
          if (m_p2[c] != m_lvl[c]) begin
            if (!m_run[c]) begin
              m_run[c]       = 1'b1;
              m_run_start[c] = ph;
            end
            if (m_tick && (((ph + 1) / TD) - (m_run_start[c] / TD)) == DEB) begin
              m_lvl[c] = ~m_lvl[c];
              m_run[c] = 1'b0;
              if (m_lvl[c]) rose = 1'b1;
              else          fell = 1'b1;
            end
          end else begin
            m_run[c] = 1'b0;
          end
          if (fell) begin
            m_held[c]  = 1'b0;
            m_e.rel[c] = 1'b1;
          end else if (m_held[c] && m_tick && ph == m_next[c]) begin
            if (m_first[c]) m_e.lng[c] = 1'b1;
            else            m_e.rep[c] = 1'b1;
            m_first[c] = 1'b0;
            m_next[c]  = (REP > 0) ? ph + REP * TD : -1;
          end
          if (rose) begin
            m_held[c]  = 1'b1;
            m_first[c] = 1'b1;
            m_next[c]  = ph + LONG * TD;
            m_e.prs[c] = 1'b1;
          end
        end
        m_p2 = m_p1;
        m_p1 = btn_in;
        ph++;
      end
      m_e.lvl = m_lvl;
      exp_q.push_back(m_e);
    end
  end

  // Monitor: one expectation per cycle, checked against both polarities.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("[TB] FAIL sb_empty at %0t: got 0 entries expected 1", $time);
      end else begin
        e = exp_q.pop_front();
        checkOutput("ah_level",   32'(ah_level),   32'(e.lvl));
        checkOutput("ah_press",   32'(ah_press),   32'(e.prs));
        checkOutput("ah_release", 32'(ah_release), 32'(e.rel));
        checkOutput("ah_long",    32'(ah_long),    32'(e.lng));
        checkOutput("ah_repeat",  32'(ah_repeat),  32'(e.rep));
        checkOutput("al_level",   32'(al_level),   32'(e.lvl));
        checkOutput("al_press",   32'(al_press),   32'(e.prs));
        checkOutput("al_release", 32'(al_release), 32'(e.rel));
        checkOutput("al_long",    32'(al_long),    32'(e.lng));
        checkOutput("al_repeat",  32'(al_repeat),  32'(e.rep));
      end
    end
  end

  initial begin : stimulus
    int found;
    int press_at;
    int long_at;
    btn_in = 2'b11;
    rst    = 1'b1;

    // Both buttons are held through reset and must then come up as a press.
    applyStimulus(2'b11, 1'b1, 3);
    btn_in = 2'b11;
    rst    = 1'b0;
    found  = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (found == 0 && ah_press == 2'b11) found = 1;
    end
    checkOutput("rst_press_within_15", 32'(found), 32'd1);
    applyStimulus(2'b11, 1'b0, 15);
    applyStimulus(2'b00, 1'b0, 30);

    // Bounce on ch0 that is too fast to debounce.
    for (int k = 0; k < 12; k++) begin
      applyStimulus((k % 2 == 0) ? 2'b01 : 2'b00, 1'b0, 5);
    end
    applyStimulus(2'b00, 1'b0, 30);

    // Clean short press on ch0.
    applyStimulus(2'b01, 1'b0, 20);
    applyStimulus(2'b00, 1'b0, 30);

    // Long press on ch1: measure the distance from press to long directly.
    btn_in   = 2'b10;
    press_at = -1000;
    long_at  = -1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (press_at < 0 && ah_press[1]) press_at = k;
      if (long_at < 0 && ah_long[1])   long_at  = k;
    end
    checkOutput("long_after_press", 32'(long_at - press_at), 32'(LONG * TD));
    applyStimulus(2'b00, 1'b0, 30);

    // Both channels pressed in the same cycle.
    applyStimulus(2'b11, 1'b0, 60);
    applyStimulus(2'b00, 1'b0, 30);

    // Reset while ch0 is in the repeat phase, with the button still held.
    applyStimulus(2'b01, 1'b0, 70);
    applyStimulus(2'b01, 1'b1, 1);
    applyStimulus(2'b01, 1'b0, 50);
    applyStimulus(2'b00, 1'b0, 30);

    // Random pin patterns with occasional resets.
    for (int k = 0; k < 30; k++) begin
      logic [1:0] pins;
      int         len;
      pins = 2'($urandom_range(0, 3));
      len  = int'($urandom_range(1, 40));
      if ($urandom_range(0, 15) == 0) applyStimulus(pins, 1'b1, 1);
      applyStimulus(pins, 1'b0, len);
    end
    applyStimulus(2'b00, 1'b0, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/btn_debounce_multi.md
# btn_debounce_multi

Multi-channel button conditioner and parametrised successor to the single-button debouncer. It synchronises and debounces N_CH raw button inputs of selectable polarity using one shared millisecond-scale tick prescaler. Per channel it produces a clean level and single-cycle press/release strobes, plus optional long-press detection and auto-repeat. It sits between the board pins and the calculator's input/menu FSM.

## Interface
- `N_CH`, 5: number of independent button channels (≥1).
- `TICK_DIV`, 100_000: clk cycles per debounce tick (1 ms at 100 MHz; ≥2).
- `DEB_TICKS`, 20: ticks of stable input required to change the debounced level (≥1).
- `LONG_TICKS`, 1000: ticks held after press before `btn_long` fires (≥1).
- `REP_TICKS`, 200: ticks between `btn_repeat` pulses after long press; 0 disables repeat.
- `ACTIVE_HIGH`, 1: 1 = pin high means pressed; 0 = pin low means pressed.
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `btn_in` in N_CH: raw asynchronous button pins.
- `btn_level` out N_CH: debounced state, 1 = pressed (polarity-normalised).
- `btn_press` out N_CH: one-cycle strobe on debounced 0→1.
- `btn_release` out N_CH: one-cycle strobe on debounced 1→0.
- `btn_long` out N_CH: one-cycle strobe when hold reaches LONG_TICKS.
- `btn_repeat` out N_CH: one-cycle strobe every REP_TICKS while held past long press.

## Operation
- Synchroniser: two flops per channel. Reset to the idle pin level (0 if ACTIVE_HIGH, 1 otherwise). Then normalise to `pressed = ACTIVE_HIGH ? sync : ~sync`.
- Prescaler: a shared counter runs 0..TICK_DIV-1 and wraps. `tick` is high for one cycle when the count equals TICK_DIV-1. The counter clears on reset.
- Debounce counter, per channel, width clog2(DEB_TICKS+1):
  - If `pressed == btn_level`, the counter clears every cycle, tick or not.
  - Otherwise it increments on each tick.
  - On the tick where the counter equals DEB_TICKS-1, `btn_level` toggles and the counter clears.
  - Any bounce back to the current level before that tick discards all progress.
- Strobes: `btn_press`/`btn_release` are registered and asserted in the same cycle that `btn_level` first shows the new value. They deassert the next cycle.
- Hold FSM, per channel, states IDLE, HELD, REPEAT. The hold counter counts ticks.
  - IDLE → HELD when `btn_level` rises; the hold counter clears.
  - HELD: the counter increments on each tick. On the tick where it reaches LONG_TICKS: pulse `btn_long`, clear the counter, go to REPEAT.
  - REPEAT: if REP_TICKS>0, count ticks and pulse `btn_repeat` every REP_TICKS ticks, clearing the counter each time. If REP_TICKS=0, stay silent.
  - Any state → IDLE when `btn_level` falls; the hold counter clears.
- Priority on a channel:
  - If release and a long/repeat event fall on the same tick, release wins and no long/repeat pulse is emitted.
  - press and release can never coincide on one channel.
- Channels are fully independent. Any combination of strobes across channels in one cycle is legal.
- Arithmetic: all counters are unsigned and saturate-free because each clears at its terminal value. Widths come from clog2 of the terminal value plus 1.

## Timing
- Reset values: `btn_level`, `btn_press`, `btn_release`, `btn_long` and `btn_repeat` are all 0. All FSMs are IDLE and all counters are 0.
- Reset mid-operation: all state is discarded next cycle. A button still held after reset must re-debounce and then produces a fresh `btn_press`.
- Press latency: from a stable pin change to `btn_level` change is between (DEB_TICKS-1)·TICK_DIV+3 and DEB_TICKS·TICK_DIV+3 cycles. This is 2 synchroniser cycles plus 1 register cycle plus tick alignment.
- Long press: `btn_long` fires exactly LONG_TICKS ticks after the `btn_press` cycle. Counting uses the first tick strictly after the press cycle.
- Repeat: successive `btn_repeat` pulses, and the first one relative to `btn_long`, are exactly REP_TICKS·TICK_DIV cycles apart.
- Every strobe is exactly 1 cycle wide and never repeats on consecutive cycles.

## Test plan
Bench parameters: N_CH=2, TICK_DIV=4, DEB_TICKS=3, LONG_TICKS=8, REP_TICKS=2, ACTIVE_HIGH=1.
- Reset state: hold `rst` for 3 cycles with `btn_in`=2'b11 → all outputs are 0 during reset. After release of reset, `btn_level[1:0]` rises within 15 cycles, with `btn_press`=2'b11 for exactly one cycle.
- Bounce rejection: ch0 toggles every 5 cycles for 60 cycles, then settles at 0 → no `btn_press[0]` and `btn_level[0]` stays 0.
- Clean press/release: ch0 goes to 1 and holds for 20 cycles, then returns to 0 → one `btn_press[0]`, `btn_level[0]` high for 20±4 cycles, one `btn_release[0]`, no `btn_long`.
- Long press and repeat: hold ch1 for 80 cycles → `btn_long[1]` 32 cycles after `btn_press[1]`, then `btn_repeat[1]` every 8 cycles until release, then one `btn_release[1]`.
- Polarity and concurrency: re-run with ACTIVE_HIGH=0 and both channels pressed (pins driven 0) in the same cycle → identical strobes on both channels in the same cycles.
- Reset mid-hold: assert `rst` for 1 cycle while ch0 is in REPEAT and still pressed → outputs clear, then a new `btn_press[0]` appears after re-debounce, with no stray `btn_release[0]`.
